antisat_key_loader: RTL

ANTISAT_KEY_LOADER -- requirements
Module: antisat_key_loader

---
 rtl/antisat_pkg.sv | 15 +
 rtl/antisat_key_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/antisat_pkg.sv
// Shared types and defaults for the Anti-SAT key loader.
// State encoding and parameter defaults live here.
package antisat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    LOCKOUT
  } state_e;

  localparam int KEY_W_DEF    = 16;
  localparam int MAX_FAIL_DEF = 3;

endpackage

// File: rtl/antisat_key_loader.sv
// Serial key loader for an Anti-SAT locked c432: shifts in a key
// plus even parity, commits on pass, locks out after repeated fails.
module antisat_key_loader
  import antisat_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_bit_valid,
  input  logic             key_bit_in,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_ready,
  output logic             busy,
  output logic             load_err,
  output logic             lockout
);

  localparam int CW = $clog2(KEY_W + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic             par_q, par_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    par_d    = par_q;
    fail_d   = fail_q;
    key_d    = key_q;
    ready_d  = ready_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shadow_d = '0;
          par_d    = 1'b0;
        end
      end
      SHIFT: begin
        // A restart pulse beats any bit offered in the same cycle
        if (load_start) begin
          cnt_d    = '0;
          shadow_d = '0;
          par_d    = 1'b0;
        end else if (key_bit_valid) begin
          par_d = par_q ^ key_bit_in;
          if (cnt_q == CW'(KEY_W)) begin
            state_d = CHECK;
          end else begin
            shadow_d = shadow_q | (KEY_W'(key_bit_in) << cnt_q);
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (!par_q) begin
          key_d   = shadow_q;
          ready_d = 1'b1;
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          err_d = 1'b1;
          if (int'(fail_q) < MAX_FAIL) begin
            fail_d = fail_q + 1'b1;
          end
          if (int'(fail_q) + 1 >= MAX_FAIL) begin
            state_d = LOCKOUT;
            key_d   = '0;
            ready_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCKOUT: begin
        key_d   = '0;
        ready_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT) || (state_d == CHECK);
    lock_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      par_q    <= 1'b0;
      fail_q   <= '0;
      key_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      par_q    <= par_d;
      fail_q   <= fail_d;
      key_q    <= key_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      lock_q   <= lock_d;
    end
  end

  assign keyinput  = key_q;
  assign key_ready = ready_q;
  assign busy      = busy_q;
  assign load_err  = err_q;
  assign lockout   = lock_q;

endmodule
